// File: rtl/dff_delay_line.sv
// Stallable WIDTH x DEPTH delay line with per-stage valid bits, flush, a selectable read tap and an occupancy count.
// All stages advance together on enable; q/q_valid come straight from the last stage register.
module dff_delay_line #(
    parameter int              WIDTH       = 7,
    parameter int              DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int              TAP_W       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           d,
    input  logic                       d_valid,
    input  logic [TAP_W-1:0]           tap_sel,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid,
    output logic [WIDTH-1:0]           q_tap,
    output logic                       q_tap_valid,
    output logic                       tap_err,
    output logic [$clog2(DEPTH+1)-1:0] fill_count
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [DEPTH-1:0]            r_vld;
    logic [CW-1:0]               r_fill;
    logic [DEPTH-1:0][WIDTH-1:0] w_din;
    logic [DEPTH-1:0]            w_vin;

    assign w_din[0] = d;
    assign w_vin[0] = d_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i > 0) begin : g_link
            assign w_din[i] = r_data[i-1];
            assign w_vin[i] = r_vld[i-1];
        end

        // clear only drops valid flags; data bits stay so the last word remains observable
        always_ff @(posedge clk) begin
            if (reset) begin
                r_data[i] <= RESET_VALUE;
                r_vld[i]  <= 1'b0;
            end else if (clear) begin
                r_vld[i]  <= 1'b0;
            end else if (enable) begin
                r_data[i] <= w_din[i];
                r_vld[i]  <= w_vin[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear)
            r_fill <= '0;
        else if (enable)
            r_fill <= r_fill + CW'(d_valid) - CW'(r_vld[DEPTH-1]);
    end

    assign q          = r_data[DEPTH-1];
    assign q_valid    = r_vld[DEPTH-1];
    assign fill_count = r_fill;

    // explicit compare loop keeps out-of-range taps (tap_sel >= DEPTH) from indexing past the array
    always_comb begin
        q_tap       = '0;
        q_tap_valid = 1'b0;
        tap_err     = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (32'(tap_sel) == i) begin
                q_tap       = r_data[i];
                q_tap_valid = r_vld[i];
                tap_err     = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dff_delay_line.sv
// Table-driven bench for dff_delay_line: each vector is queued as expected output when driven
// and popped for comparison one edge later; tap sweeps cover the combinational read port.
module tb_dff_delay_line;
    localparam int W  = 7;
    localparam int D  = 4;
    localparam int TW = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset, enable, clear, d_valid;
    logic [W-1:0]  d;
    logic [TW-1:0] tap_sel;
    logic [W-1:0]  q, q_tap;
    logic          q_valid, q_tap_valid, tap_err;
    logic [CW-1:0] fill_count;

    always #5 clk = ~clk;

    dff_delay_line #(.WIDTH(W), .DEPTH(D), .RESET_VALUE('0), .TAP_W(TW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .d(d), .d_valid(d_valid), .tap_sel(tap_sel),
        .q(q), .q_valid(q_valid), .q_tap(q_tap), .q_tap_valid(q_tap_valid),
        .tap_err(tap_err), .fill_count(fill_count)
    );

    typedef struct {
        logic          rst, en, clr;
        logic [W-1:0]  d;
        logic          dv;
        logic [TW-1:0] tap;
        logic [W-1:0]  q;
        logic          qv;
        logic [W-1:0]  qt;
        logic          qtv, err;
        logic [CW-1:0] fill;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   idx_rst1, idx_tap, idx_rst2;

    function automatic vec_t mk(input logic rst, en, clr, input logic [W-1:0] dd, input logic dv,
                                input logic [TW-1:0] tp, input logic [W-1:0] eq, input logic eqv,
                                input logic [W-1:0] et, input logic etv, eerr, input logic [CW-1:0] ef);
        vec_t v;
        v.rst = rst; v.en = en; v.clr = clr; v.d = dd; v.dv = dv; v.tap = tp;
        v.q = eq; v.qv = eqv; v.qt = et; v.qtv = etv; v.err = eerr; v.fill = ef;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic check_outs(input int idx, input vec_t e);
        chk("q",           idx, 32'(q),           32'(e.q));
        chk("q_valid",     idx, 32'(q_valid),     32'(e.qv));
        chk("q_tap",       idx, 32'(q_tap),       32'(e.qt));
        chk("q_tap_valid", idx, 32'(q_tap_valid), 32'(e.qtv));
        chk("tap_err",     idx, 32'(tap_err),     32'(e.err));
        chk("fill_count",  idx, 32'(fill_count),  32'(e.fill));
    endtask

    // Walk every tap_sel value with the pipe held; stages 0..3 expected s0..s3 with valid v
    task automatic sweep(input int idx, input logic [W-1:0] s0, s1, s2, s3, input logic v);
        logic [W-1:0] ev[4];
        ev[0] = s0; ev[1] = s1; ev[2] = s2; ev[3] = s3;
        reset = 1'b0; enable = 1'b0; clear = 1'b0;
        for (int t = 0; t < 16; t++) begin
            tap_sel = TW'(t);
            #1;
            if (t < D) begin
                chk("sweep_tap",   idx * 100 + t, 32'(q_tap),       32'(ev[t]));
                chk("sweep_tapv",  idx * 100 + t, 32'(q_tap_valid), 32'(v));
                chk("sweep_err",   idx * 100 + t, 32'(tap_err),     32'(0));
            end else begin
                chk("sweep_tap",   idx * 100 + t, 32'(q_tap),       32'(0));
                chk("sweep_tapv",  idx * 100 + t, 32'(q_tap_valid), 32'(0));
                chk("sweep_err",   idx * 100 + t, 32'(tap_err),     32'(1));
            end
        end
    endtask

    initial begin
        // reset held two edges with live input
        tbl.push_back(mk(1,1,0,'h55,1,0,  0,0,  0,0,0, 0));
        tbl.push_back(mk(1,1,0,'h55,1,3,  0,0,  0,0,0, 0));
        idx_rst1 = tbl.size() - 1;
        // fill and latency
        tbl.push_back(mk(0,1,0, 1,1,0,    0,0,  1,1,0, 1));
        tbl.push_back(mk(0,1,0, 2,1,1,    0,0,  1,1,0, 2));
        tbl.push_back(mk(0,1,0, 3,1,2,    0,0,  1,1,0, 3));
        tbl.push_back(mk(0,1,0, 4,1,3,    1,1,  1,1,0, 4));
        tbl.push_back(mk(0,1,0, 5,1,0,    2,1,  5,1,0, 4));
        // stall with moving d, then resume
        tbl.push_back(mk(0,0,0,20,1,0,    2,1,  5,1,0, 4));
        tbl.push_back(mk(0,0,0,21,1,0,    2,1,  5,1,0, 4));
        tbl.push_back(mk(0,0,0,22,0,0,    2,1,  5,1,0, 4));
        tbl.push_back(mk(0,1,0, 9,1,0,    3,1,  9,1,0, 4));
        // bubbles from empty
        tbl.push_back(mk(1,0,0, 0,0,0,    0,0,  0,0,0, 0));
        tbl.push_back(mk(0,1,0,10,1,0,    0,0, 10,1,0, 1));
        tbl.push_back(mk(0,1,0,11,0,1,    0,0, 10,1,0, 1));
        tbl.push_back(mk(0,1,0,12,1,2,    0,0, 10,1,0, 2));
        tbl.push_back(mk(0,1,0,13,0,3,   10,1, 10,1,0, 2));
        tbl.push_back(mk(0,1,0,20,1,0,   11,0, 20,1,0, 2));
        tbl.push_back(mk(0,1,0,21,1,3,   12,1, 12,1,0, 3));
        tbl.push_back(mk(0,1,0,22,1,2,   13,0, 20,1,0, 3));
        tbl.push_back(mk(0,1,0,23,1,1,   20,1, 22,1,0, 4));
        // clear beats enable; 7F must not be captured
        tbl.push_back(mk(0,1,1,'h7F,1,0, 20,0, 23,0,0, 0));
        tbl.push_back(mk(0,0,0,'h7F,1,0, 20,0, 23,0,0, 0));
        // refill to 4,3,2,1
        tbl.push_back(mk(0,1,0, 1,1,0,   21,0,  1,1,0, 1));
        tbl.push_back(mk(0,1,0, 2,1,0,   22,0,  2,1,0, 2));
        tbl.push_back(mk(0,1,0, 3,1,3,   23,0, 23,0,0, 3));
        tbl.push_back(mk(0,1,0, 4,1,1,    1,1,  3,1,0, 4));
        tbl.push_back(mk(0,0,0, 0,0,5,    1,1,  0,0,1, 4));
        idx_tap = tbl.size() - 1;
        // reset mid-stream, then refill from scratch
        tbl.push_back(mk(1,1,0, 7,1,1,    0,0,  0,0,0, 0));
        idx_rst2 = tbl.size() - 1;
        tbl.push_back(mk(0,1,0,30,1,0,    0,0, 30,1,0, 1));
        tbl.push_back(mk(0,1,0,31,1,1,    0,0, 30,1,0, 2));
        tbl.push_back(mk(0,1,0,32,1,2,    0,0, 30,1,0, 3));
        tbl.push_back(mk(0,1,0,33,1,3,   30,1, 30,1,0, 4));

        reset = 1'b1; enable = 1'b0; clear = 1'b0; d = '0; d_valid = 1'b0; tap_sel = '0;
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v, e;
            v = tbl[i];
            reset = v.rst; enable = v.en; clear = v.clr;
            d = v.d; d_valid = v.dv; tap_sel = v.tap;
            sb.push_back(v);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_outs(i, e);
            if (i == idx_rst1 || i == idx_rst2)
                sweep(i, 0, 0, 0, 0, 1'b0);
            else if (i == idx_tap)
                sweep(i, 4, 3, 2, 1, 1'b1);
        end
        chk("sb_drained", 0, 32'(sb.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
